// File: rtl/grf_wport_arbiter.sv
// GRF write-port arbiter.
// The pipeline WB stage and a multi-cycle aux unit both want the single GRF
// write port. Aux results are buffered in a 2-entry FIFO and normally lose to
// WB. After MAX_WAIT consecutive losses the aux head is forced through, and WB
// is stalled for that one cycle.
module grf_wport_arbiter #(
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic [31:0] wb_pc,
   input  logic        aux_valid,
   input  logic [4:0]  aux_addr,
   input  logic [31:0] aux_data,
   input  logic [31:0] aux_pc,
   output logic        aux_ready,
   output logic        wb_stall,
   output logic        grf_we,
   output logic [4:0]  grf_addr,
   output logic [31:0] grf_data,
   output logic [31:0] grf_pc
);

   // The counter must be able to represent MAX_WAIT itself.
   localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] STARVE_MAX = CW'(MAX_WAIT);

   logic [4:0]    r_fifoAddr [2];
   logic [31:0]   r_fifoData [2];
   logic [31:0]   r_fifoPc   [2];
   logic          r_wrPtr;
   logic          r_rdPtr;
   logic [1:0]    r_count;
   logic [CW-1:0] r_starve;

   logic w_empty;
   logic w_full;
   logic w_wbReq;
   logic w_starveMax;
   logic w_auxWins;
   logic w_wbGrant;
   logic w_push;
   logic w_pop;

   // Request decode and the arbitration decision, all taken from the current
   // FIFO head only so a freshly pushed entry cannot be granted the same cycle.
   always_comb begin
      w_empty     = (r_count == 2'd0);
      w_full      = (r_count == 2'd2);
      w_wbReq     = wb_we && (wb_addr != 5'd0);
      w_starveMax = (r_starve == STARVE_MAX);
      w_auxWins   = !w_empty && (!w_wbReq || w_starveMax);
      w_wbGrant   = w_wbReq && !w_auxWins;
      aux_ready   = !w_full && !reset;
      wb_stall    = w_wbReq && !w_empty && w_starveMax && !reset;
      w_push      = aux_valid && aux_ready;
      w_pop       = w_auxWins;
   end

   // FIFO storage and pointers; a push into a non-full FIFO and a pop of the
   // head may happen together, leaving occupancy unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrPtr       <= 1'b0;
         r_rdPtr       <= 1'b0;
         r_count       <= 2'd0;
         r_fifoAddr[0] <= 5'd0;
         r_fifoAddr[1] <= 5'd0;
         r_fifoData[0] <= 32'd0;
         r_fifoData[1] <= 32'd0;
         r_fifoPc[0]   <= 32'd0;
         r_fifoPc[1]   <= 32'd0;
      end else begin
         if (w_push) begin
            r_fifoAddr[r_wrPtr] <= aux_addr;
            r_fifoData[r_wrPtr] <= aux_data;
            r_fifoPc[r_wrPtr]   <= aux_pc;
            r_wrPtr             <= ~r_wrPtr;
         end
         if (w_pop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Starvation counter: counts WB wins over a waiting aux head, clears when
   // the aux side is served or has nothing waiting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_starve <= '0;
      end else if (w_auxWins || w_empty) begin
         r_starve <= '0;
      end else if (w_wbGrant && !w_starveMax) begin
         r_starve <= r_starve + CW'(1);
      end
   end

   // Registered GRF write port; a dropped $0 aux write and idle cycles leave
   // the address/data/pc fields at their last written values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grf_we   <= 1'b0;
         grf_addr <= 5'd0;
         grf_data <= 32'd0;
         grf_pc   <= 32'd0;
      end else if (w_auxWins && (r_fifoAddr[r_rdPtr] != 5'd0)) begin
         grf_we   <= 1'b1;
         grf_addr <= r_fifoAddr[r_rdPtr];
         grf_data <= r_fifoData[r_rdPtr];
         grf_pc   <= r_fifoPc[r_rdPtr];
      end else if (w_wbGrant) begin
         grf_we   <= 1'b1;
         grf_addr <= wb_addr;
         grf_data <= wb_data;
         grf_pc   <= wb_pc;
      end else begin
         grf_we   <= 1'b0;
      end
   end

endmodule
